// File: rtl/bm_noise_out_if.sv
// ---------------------------------------------------------------------------
// bm_noise_out_if
// Stream bundle for the Box-Muller output stage.
//   Input side : in_valid / in_ready handshake carrying f (17b unsigned,
//                13 frac), g0 = cos term and g1 = sin term (16b signed,
//                15 frac).
//   Output side: out_valid / out_ready handshake carrying out_data (16b
//                signed, 11 frac) and out_idx (0 = x0, 1 = x1).
// The master modport is the environment (upstream producer plus downstream
// consumer); the slave modport is the noise output block itself.
// ---------------------------------------------------------------------------
interface bm_noise_out_if;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] f;
   logic [15:0] g0;
   logic [15:0] g1;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_idx;

   modport master (
      output in_valid, f, g0, g1, out_ready,
      input  in_ready, out_valid, out_data, out_idx
   );

   modport slave (
      input  in_valid, f, g0, g1, out_ready,
      output in_ready, out_valid, out_data, out_idx
   );
endinterface

// File: rtl/bm_noise_out.sv
// ---------------------------------------------------------------------------
// bm_noise_out
// Last stage of the Box-Muller AWGN chain. Multiplies the magnitude f by the
// cos/sin pair, rounds both products to the (16,11) noise format, stores
// the result pairs in a small FIFO and serialises them as x0 then x1.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : stream interface (slave side), see bm_noise_out_if
//   fifo_level : number of pairs stored in the FIFO (0..DEPTH)
// Pipeline: accept edge captures inputs (s0), next edge registers the
// products (s1), next edge registers the rounded pair (s2), next edge
// writes the FIFO. in_ready is a credit check over everything accepted
// but not yet popped, so the FIFO can never overflow.
// ---------------------------------------------------------------------------
module bm_noise_out #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   bm_noise_out_if.slave bus,
   output logic [AW:0]   fifo_level
);
   typedef enum logic {HALF0 = 1'b0, HALF1 = 1'b1} half_t;

   logic               init_reg;
   logic               s0_valid_reg;
   logic [16:0]        s0_f_reg;
   logic [15:0]        s0_g0_reg;
   logic [15:0]        s0_g1_reg;
   logic               s1_valid_reg;
   logic signed [33:0] s1_p0_reg;
   logic signed [33:0] s1_p1_reg;
   logic               s2_valid_reg;
   logic [15:0]        s2_x0_reg;
   logic [15:0]        s2_x1_reg;
   logic [31:0]        mem [DEPTH];
   logic [AW-1:0]      wr_ptr_reg;
   logic [AW-1:0]      rd_ptr_reg;
   logic [AW:0]        level_reg;
   half_t              half_reg;

   logic               accept;
   logic               push;
   logic               pop;
   logic [AW+1:0]      occupancy;
   logic [33:0]        f_ext;
   logic [33:0]        g0_ext;
   logic [33:0]        g1_ext;
   logic signed [33:0] rnd0;
   logic signed [33:0] rnd1;
   logic [31:0]        head;
   logic               rnd_unused;

   // f is unsigned, g is signed: extend each to the full product width so
   // the low 34 bits of the multiply are the exact signed product.
   assign f_ext  = {17'b0, s0_f_reg};
   assign g0_ext = {{18{s0_g0_reg[15]}}, s0_g0_reg};
   assign g1_ext = {{18{s0_g1_reg[15]}}, s0_g1_reg};

   // Round half toward +inf: add half an output LSB, then drop 17 bits.
   // |x| <= 32768 by construction, so bits [32:17] hold the result.
   assign rnd0 = s1_p0_reg + 34'sd65536;
   assign rnd1 = s1_p1_reg + 34'sd65536;
   assign rnd_unused = ^{rnd0[33], rnd0[16:0], rnd1[33], rnd1[16:0]};

   // Credit counts stored pairs plus every pipeline stage in flight.
   assign occupancy = (AW+2)'(level_reg) + (AW+2)'(s0_valid_reg)
                    + (AW+2)'(s1_valid_reg) + (AW+2)'(s2_valid_reg);

   assign bus.in_ready  = init_reg && (occupancy <= (AW+2)'(DEPTH - 1));
   assign accept        = bus.in_valid && bus.in_ready;
   assign push          = s2_valid_reg;
   assign bus.out_valid = (level_reg != '0);
   assign pop           = bus.out_valid && bus.out_ready && (half_reg == HALF1);

   assign head          = mem[rd_ptr_reg];
   // Gate with out_valid so an empty FIFO (and reset) shows zero data.
   assign bus.out_data  = !bus.out_valid     ? 16'h0000 :
                          (half_reg == HALF1) ? head[31:16] : head[15:0];
   assign bus.out_idx   = (half_reg == HALF1);
   assign fifo_level    = level_reg;

   // Datapath, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_reg     <= 1'b0;
         s0_valid_reg <= 1'b0;
         s0_f_reg     <= '0;
         s0_g0_reg    <= '0;
         s0_g1_reg    <= '0;
         s1_valid_reg <= 1'b0;
         s1_p0_reg    <= '0;
         s1_p1_reg    <= '0;
         s2_valid_reg <= 1'b0;
         s2_x0_reg    <= '0;
         s2_x1_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
      end else begin
         init_reg     <= 1'b1;
         s0_valid_reg <= accept;
         if (accept) begin
            s0_f_reg  <= bus.f;
            s0_g0_reg <= bus.g0;
            s0_g1_reg <= bus.g1;
         end
         s1_valid_reg <= s0_valid_reg;
         s1_p0_reg    <= $signed(f_ext * g0_ext);
         s1_p1_reg    <= $signed(f_ext * g1_ext);
         s2_valid_reg <= s1_valid_reg;
         s2_x0_reg    <= rnd0[32:17];
         s2_x1_reg    <= rnd1[32:17];
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         level_reg <= level_reg + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Pair storage; contents need no reset because reads are gated by level.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {s2_x1_reg, s2_x0_reg};
   end

   // Serializer: x0 in HALF0, x1 in HALF1; the pair leaves on the HALF1
   // handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_reg <= HALF0;
      end else if (bus.out_valid && bus.out_ready) begin
         case (half_reg)
            HALF0:   half_reg <= HALF1;
            default: half_reg <= HALF0;
         endcase
      end
   end
endmodule

// File: tb/tb_bm_noise_out.sv
// ---------------------------------------------------------------------------
// tb_bm_noise_out
// Directed bench for bm_noise_out. A reference model holds every accepted
// pair (computed with real arithmetic from the fixed-point formats) together
// with the edge it was accepted on; a per-cycle monitor derives the expected
// in_ready, out_valid, fifo_level and output sample from it. Directed
// sequences add literal expectations for reset, latency, rounding, full and
// reset-mid-stream behaviour.
// ---------------------------------------------------------------------------
module tb_bm_noise_out;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [AW:0] fifo_level;

   bm_noise_out_if bif();

   bm_noise_out #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bif),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     x0;
      int     x1;
      longint acc_edge;
   } pair_t;

   int     checks = 0;
   int     errors = 0;
   pair_t  pending[$];
   longint edge_cnt = 0;
   int     rel_edges = 0;
   bit     half = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // f is (17,13) unsigned, g is (16,15) signed, result in (16,11) LSBs,
   // rounded half toward +inf.
   function automatic int model_x(input logic [16:0] fv, input logic [15:0] gv);
      real fr;
      real gr;
      real xr;
      fr = real'(fv) / 8192.0;
      gr = real'($signed(gv)) / 32768.0;
      xr = fr * gr * 2048.0;
      return int'($floor(xr + 0.5));
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         edge_cnt++;
         rel_edges++;
      end
   end

   // Per-cycle monitor: checks the DUT against the model, then records the
   // handshakes that the coming rising edge will perform.
   always @(negedge clk) begin
      int    lvl;
      bit    exp_valid;
      bit    exp_ready;
      pair_t p;
      if (!rst_n) begin
         check("rst_out_valid", bif.out_valid, 0);
         check("rst_in_ready", bif.in_ready, 0);
         check("rst_fifo_level", fifo_level, 0);
         check("rst_out_data", bif.out_data, 0);
         check("rst_out_idx", bif.out_idx, 0);
         pending.delete();
         half = 1'b0;
         rel_edges = 0;
      end else begin
         lvl = 0;
         foreach (pending[i]) if (pending[i].acc_edge + 3 <= edge_cnt) lvl++;
         exp_valid = (lvl != 0);
         exp_ready = (rel_edges >= 1) && (pending.size() < DEPTH);
         check("mon_in_ready", bif.in_ready, exp_ready);
         check("mon_out_valid", bif.out_valid, exp_valid);
         check("mon_fifo_level", fifo_level, lvl);
         if (exp_valid) begin
            check("mon_out_idx", bif.out_idx, half);
            check("mon_out_data", $signed(bif.out_data),
                  half ? pending[0].x1 : pending[0].x0);
         end
         if (bif.in_valid && exp_ready) begin
            p.x0 = model_x(bif.f, bif.g0);
            p.x1 = model_x(bif.f, bif.g1);
            p.acc_edge = edge_cnt + 1;
            pending.push_back(p);
         end
         if (exp_valid && bif.out_ready) begin
            if (half) begin
               void'(pending.pop_front());
               half = 1'b0;
            end else begin
               half = 1'b1;
            end
         end
      end
   end

   task automatic send(input logic [16:0] fv, input logic [15:0] a, input logic [15:0] b);
      int n;
      bif.in_valid = 1'b1;
      bif.f  = fv;
      bif.g0 = a;
      bif.g1 = b;
      n = 0;
      @(negedge clk);
      while (!bif.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed %0d, required 1", bif.in_ready);
      end
      @(posedge clk);
      #1;
      bif.in_valid = 1'b0;
   endtask

   // Waits (bounded) for out_valid, checks the sample, consumes it.
   task automatic expect_sample(input string name, input int exp_data, input int exp_idx);
      int n;
      n = 0;
      @(negedge clk);
      while (!bif.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, bif.out_valid, 1);
      check({name, "_data"}, $signed(bif.out_data), exp_data);
      check({name, "_idx"}, bif.out_idx, exp_idx);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      bif.out_ready = 1'b1;
      n = 0;
      while ((pending.size() != 0 || fifo_level != 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_level", fifo_level, 0);
   endtask

   initial begin
      int acc;
      int duty;
      bif.in_valid  = 1'b0;
      bif.f         = '0;
      bif.g0        = '0;
      bif.g1        = '0;
      bif.out_ready = 1'b1;
      rst_n         = 1'b0;

      // Reset with random inputs.
      repeat (5) begin
         @(posedge clk);
         #1;
         bif.in_valid  = 1'($urandom);
         bif.f         = 17'($urandom);
         bif.g0        = 16'($urandom);
         bif.g1        = 16'($urandom);
         bif.out_ready = 1'($urandom);
      end
      check("reset_out_valid", bif.out_valid, 0);
      check("reset_in_ready", bif.in_ready, 0);
      check("reset_level", fifo_level, 0);
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_before_edge", bif.in_ready, 0);
      @(negedge clk);
      check("ready_after_edge", bif.in_ready, 1);
      @(posedge clk);
      #1;

      // Single pair and latency: low after T, T+1, T+2; high after T+3.
      send(17'h02000, 16'h4000, 16'hC000);
      repeat (3) begin
         @(negedge clk);
         check("lat_low", bif.out_valid, 0);
      end
      @(negedge clk);
      check("lat_high", bif.out_valid, 1);
      check("single_x0", $signed(bif.out_data), 1024);
      check("single_idx0", bif.out_idx, 0);
      @(posedge clk);
      #1;
      expect_sample("single_x1", -1024, 1);

      // Rounding and extremes, f == 0.
      bif.out_ready = 1'b0;
      send(17'h1FFFF, 16'h8000, 16'h0000);
      send(17'h00001, 16'h7FFF, 16'h0000);
      send(17'h00003, 16'h0000, 16'h7FFF);
      send(17'h00000, 16'h7FFF, 16'h8000);
      bif.out_ready = 1'b1;
      expect_sample("neg_full_x0", -32768, 0);
      expect_sample("neg_full_x1", 0, 1);
      expect_sample("tiny_x0", 0, 0);
      expect_sample("tiny_x1", 0, 1);
      expect_sample("three_x0", 0, 0);
      expect_sample("three_x1", 1, 1);
      expect_sample("fzero_x0", 0, 0);
      expect_sample("fzero_x1", 0, 1);
      drain();

      // Backpressure: exactly DEPTH pairs accepted, FIFO full.
      bif.out_ready = 1'b0;
      bif.in_valid  = 1'b1;
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         bif.f  = 17'($urandom);
         bif.g0 = 16'($urandom);
         bif.g1 = 16'($urandom);
         @(negedge clk);
         if (bif.in_valid && bif.in_ready) acc++;
         @(posedge clk);
         #1;
      end
      bif.in_valid = 1'b0;
      check("full_accepted", acc, DEPTH);
      @(negedge clk);
      check("full_level", fifo_level, DEPTH);
      check("full_in_ready", bif.in_ready, 0);
      check("full_out_valid", bif.out_valid, 1);
      @(posedge clk);
      #1;
      drain();

      // Streaming with random data.
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      duty = 0;
      for (int c = 0; c < 200; c++) begin
         bif.f  = 17'($urandom);
         bif.g0 = 16'($urandom);
         bif.g1 = 16'($urandom);
         @(negedge clk);
         if (bif.out_valid) duty++;
         @(posedge clk);
         #1;
      end
      bif.in_valid = 1'b0;
      check("stream_duty_ge_half", (duty >= 100) ? 1 : 0, 1);
      drain();

      // Reset mid-stream: 3 pairs stored, 2 in flight.
      bif.out_ready = 1'b0;
      bif.in_valid  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         bif.f  = 17'($urandom);
         bif.g0 = 16'($urandom);
         bif.g1 = 16'($urandom);
         @(posedge clk);
         #1;
      end
      bif.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_level_before", fifo_level, 3);
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", bif.out_valid, 0);
      check("mid_level", fifo_level, 0);
      check("mid_in_ready", bif.in_ready, 0);
      check("mid_out_data", bif.out_data, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bif.out_ready = 1'b1;
      send(17'h02000, 16'h2000, 16'h6000);
      expect_sample("post_x0", 512, 0);
      expect_sample("post_x1", 1536, 1);
      repeat (10) @(posedge clk);
      #1;
      check("post_idle_valid", bif.out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
